// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM address/data plus the decode
// valid/ready handshake and the branch/jump redirect request.
interface instruction_fetch_unit_if;
    logic [11:0] imem_address;
    logic [18:0] imem_instruction;
    logic [18:0] instr_out;
    logic [11:0] pc_out;
    logic        instr_valid;
    logic        decode_ready;
    logic        redirect_valid;
    logic [11:0] redirect_target;

    // The fetch unit drives the ROM address and the decode-facing outputs
    modport master (
        output imem_address,
        input  imem_instruction,
        output instr_out,
        output pc_out,
        output instr_valid,
        input  decode_ready,
        input  redirect_valid,
        input  redirect_target
    );

    // ROM and decode side: returns instruction words, accepts, redirects
    modport slave (
        input  imem_address,
        output imem_instruction,
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        output decode_ready,
        output redirect_valid,
        output redirect_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues addresses to a 1-cycle-latency instruction
// ROM, pairs each returned word with its PC and hands it to decode over a
// valid/ready handshake. Handles branch/jump redirect and stops on a halt word.
module instruction_fetch_unit #(
    parameter logic [11:0] RESET_PC  = 12'd0,
    parameter logic [18:0] HALT_WORD = 19'h7FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    instruction_fetch_unit_if.master bus,
    output logic                     halted,
    output logic [CNT_W-1:0]         fetch_count
);

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    fetch_state_t     state, state_next;
    logic [11:0]      pc_reg, pc_next;
    logic [11:0]      inflight_pc, inflight_pc_next;
    logic             inflight_valid, inflight_valid_next;
    logic [CNT_W-1:0] count_next;
    logic             fire;
    logic             stall;

    // Register update; async reset restarts fetching from RESET_PC
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            pc_reg         <= RESET_PC;
            inflight_pc    <= 12'd0;
            inflight_valid <= 1'b0;
            fetch_count    <= '0;
        end else begin
            state          <= state_next;
            pc_reg         <= pc_next;
            inflight_pc    <= inflight_pc_next;
            inflight_valid <= inflight_valid_next;
            fetch_count    <= count_next;
        end
    end

    // Handshake outputs, ROM address and next-state selection in priority order
    always_comb begin
        state_next          = state;
        pc_next             = pc_reg;
        inflight_pc_next    = inflight_pc;
        inflight_valid_next = inflight_valid;
        count_next          = fetch_count;

        bus.instr_valid  = inflight_valid && (state == RUN) && !bus.redirect_valid;
        bus.instr_out    = bus.imem_instruction;
        bus.pc_out       = inflight_pc;
        fire             = bus.instr_valid && bus.decode_ready;
        stall            = bus.instr_valid && !bus.decode_ready;
        // On a stall the ROM re-reads the held PC so instr_out stays stable
        bus.imem_address = stall ? inflight_pc : pc_reg;
        halted           = (state == HALTED);

        if (fire && (fetch_count != '1)) begin
            count_next = fetch_count + CNT_W'(1);
        end

        if (bus.redirect_valid) begin
            pc_next             = bus.redirect_target;
            inflight_valid_next = 1'b0;
            state_next          = RUN;
        end else if (state == HALTED) begin
            state_next = HALTED;
        end else if (fire && (bus.instr_out == HALT_WORD)) begin
            state_next          = HALTED;
            inflight_valid_next = 1'b0;
        end else if (stall) begin
            pc_next = pc_reg;
        end else begin
            inflight_pc_next    = pc_reg;
            inflight_valid_next = 1'b1;
            pc_next             = pc_reg + 12'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a behavioural
// 1-cycle-latency instruction ROM. ROM word at address a is 19'h10000 | a
// unless a test overwrites it with the halt word.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        halted;
    logic [15:0] fetch_count;
    logic [18:0] rom [0:4095];
    int          checks;
    int          passed;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read instruction ROM
    always @(posedge clock) begin
        bus.imem_instruction <= rom[bus.imem_address];
    end

    // Hold reset for two cycles, release between edges
    task automatic do_reset();
        reset_n             = 1'b0;
        bus.decode_ready    = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 12'd0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n             = 1'b0;
        bus.decode_ready    = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 12'd0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.instr_valid);
        else passed++;
        checks++;
        if (halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b expected 0", halted);
        else passed++;
        checks++;
        if (bus.pc_out !== 12'd0) $display("[TB] FAIL reset_pc_out: got %0d expected 0", bus.pc_out);
        else passed++;
        checks++;
        if (bus.imem_address !== 12'd0) $display("[TB] FAIL reset_imem_address: got %0d expected 0", bus.imem_address);
        else passed++;
        checks++;
        if (fetch_count !== 16'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count);
        else passed++;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0) $display("[TB] FAIL bubble_valid: got %b expected 0", bus.instr_valid);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [18:0] exp_instr [0:3];
        exp_instr[0] = 19'h10000;
        exp_instr[1] = 19'h10001;
        exp_instr[2] = 19'h10002;
        exp_instr[3] = 19'h10003;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (bus.instr_valid !== 1'b1) $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", k, bus.instr_valid);
            else passed++;
            checks++;
            if (bus.instr_out !== exp_instr[k]) $display("[TB] FAIL seq_instr[%0d]: got %h expected %h", k, bus.instr_out, exp_instr[k]);
            else passed++;
            checks++;
            if (bus.pc_out !== 12'(k)) $display("[TB] FAIL seq_pc[%0d]: got %0d expected %0d", k, bus.pc_out, k);
            else passed++;
        end
        @(negedge clock);
        checks++;
        if (fetch_count !== 16'd4) $display("[TB] FAIL seq_count: got %0d expected 4", fetch_count);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        bus.decode_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd2 || bus.instr_out !== 19'h10002)
                $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%0d instr=%h expected v=1 pc=2 instr=10002",
                         k, bus.instr_valid, bus.pc_out, bus.instr_out);
            else passed++;
            checks++;
            if (bus.imem_address !== 12'd2) $display("[TB] FAIL stall_addr[%0d]: got %0d expected 2", k, bus.imem_address);
            else passed++;
        end
        bus.decode_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd3 || bus.instr_out !== 19'h10003)
            $display("[TB] FAIL stall_resume: got v=%b pc=%0d instr=%h expected v=1 pc=3 instr=10003",
                     bus.instr_valid, bus.pc_out, bus.instr_out);
        else passed++;
        checks++;
        if (fetch_count !== 16'd3) $display("[TB] FAIL stall_count: got %0d expected 3", fetch_count);
        else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 6; k++) @(negedge clock);
        checks++;
        if (bus.pc_out !== 12'd5) $display("[TB] FAIL redir_pre_pc: got %0d expected 5", bus.pc_out);
        else passed++;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'd100;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0) $display("[TB] FAIL redir_kill_valid: got %b expected 0", bus.instr_valid);
        else passed++;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0) $display("[TB] FAIL redir_bubble_valid: got %b expected 0", bus.instr_valid);
        else passed++;
        checks++;
        if (bus.imem_address !== 12'd100) $display("[TB] FAIL redir_addr: got %0d expected 100", bus.imem_address);
        else passed++;
        @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd100 || bus.instr_out !== 19'h10064)
            $display("[TB] FAIL redir_target: got v=%b pc=%0d instr=%h expected v=1 pc=100 instr=10064",
                     bus.instr_valid, bus.pc_out, bus.instr_out);
        else passed++;
        checks++;
        if (fetch_count !== 16'd5) $display("[TB] FAIL redir_count: got %0d expected 5", fetch_count);
        else passed++;
    endtask

    task automatic test_halt();
        rom[3] = 19'h7FFFF;
        do_reset();
        for (int k = 0; k < 4; k++) @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd3 || bus.instr_out !== 19'h7FFFF)
            $display("[TB] FAIL halt_word: got v=%b pc=%0d instr=%h expected v=1 pc=3 instr=7ffff",
                     bus.instr_valid, bus.pc_out, bus.instr_out);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (halted !== 1'b1 || bus.instr_valid !== 1'b0)
                $display("[TB] FAIL halt_state[%0d]: got halted=%b v=%b expected halted=1 v=0", k, halted, bus.instr_valid);
            else passed++;
            checks++;
            if (fetch_count !== 16'd4) $display("[TB] FAIL halt_count[%0d]: got %0d expected 4", k, fetch_count);
            else passed++;
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'd0;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("[TB] FAIL halt_leave: got halted=%b v=%b expected halted=0 v=0", halted, bus.instr_valid);
        else passed++;
        @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd0 || bus.instr_out !== 19'h10000)
            $display("[TB] FAIL halt_resume: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=10000",
                     bus.instr_valid, bus.pc_out, bus.instr_out);
        else passed++;
        rom[3] = 19'h10003;
    endtask

    task automatic test_wrap();
        logic [11:0] exp_pc [0:3];
        exp_pc[0] = 12'd4094;
        exp_pc[1] = 12'd4095;
        exp_pc[2] = 12'd0;
        exp_pc[3] = 12'd1;
        do_reset();
        @(negedge clock);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'd4094;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.pc_out !== exp_pc[k] || bus.instr_out !== (19'h10000 | {7'd0, exp_pc[k]}))
                $display("[TB] FAIL wrap[%0d]: got v=%b pc=%0d instr=%h expected v=1 pc=%0d",
                         k, bus.instr_valid, bus.pc_out, bus.instr_out, exp_pc[k]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        rom[1] = 19'h7FFFF;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (halted !== 1'b1 || fetch_count !== 16'd2)
            $display("[TB] FAIL areset_pre: got halted=%b count=%0d expected halted=1 count=2", halted, fetch_count);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("[TB] FAIL areset_now: got halted=%b v=%b expected halted=0 v=0", halted, bus.instr_valid);
        else passed++;
        checks++;
        if (fetch_count !== 16'd0 || bus.imem_address !== 12'd0)
            $display("[TB] FAIL areset_regs: got count=%0d addr=%0d expected count=0 addr=0", fetch_count, bus.imem_address);
        else passed++;
        rom[1] = 19'h10001;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 12'd0 || bus.instr_out !== 19'h10000)
            $display("[TB] FAIL areset_refetch: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=10000",
                     bus.instr_valid, bus.pc_out, bus.instr_out);
        else passed++;
    endtask

    // Run every scenario in sequence, then report
    initial begin
        checks = 0;
        passed = 0;
        for (int a = 0; a < 4096; a++) rom[a] = 19'h10000 | 19'(a);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
